// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-master memory arbiter: owner encoding,
// master ids and the beat-counter sizing helper.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      OWNER_IDLE = 2'd0,
      OWNER_M0   = 2'd1,
      OWNER_M1   = 2'd2
   } owner_e;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   // Enough bits to hold 0..burst_max inclusive.
   function automatic int beat_cnt_w(input int burst_max);
      return $clog2(burst_max + 1);
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between two
// masters, with bounded ownership runs and routed read returns.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int BURST_MAX = 4
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [DW-1:0] rdata,
   output logic [AW-1:0] mem_address,
   output logic [DW-1:0] mem_data_out,
   output logic          mem_we,
   input  logic [DW-1:0] mem_data_in,
   output owner_e        dbg_state
);

   localparam int            CW      = beat_cnt_w(BURST_MAX);
   localparam logic [CW-1:0] CNT_MAX = CW'(BURST_MAX);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   // Handshake: a master raises req with we/addr/wdata; a beat transfers in
   // the cycle where req & gnt are both high. gnt is combinational and may
   // move to the other master within the same cycle the owner drops req.
   // A read beat is answered by a one-cycle rvalid pulse on the next cycle.

   owner_e        state, state_n;
   logic          last, last_n;
   logic [CW-1:0] beat_cnt, cnt_n;
   logic          rd_pend, rd_id;

   logic          grant_any;
   logic          grant_id;
   logic          owner_id;
   logic          owner_req;
   logic          other_req;
   logic          gnt_ok;
   logic          read_beat;

   always_comb begin
      grant_any = 1'b0;
      grant_id  = M0;
      state_n   = state;
      last_n    = last;
      cnt_n     = beat_cnt;
      owner_id  = (state == OWNER_M1) ? M1 : M0;
      owner_req = (owner_id == M1) ? m1_req : m0_req;
      other_req = (owner_id == M1) ? m0_req : m1_req;

      case (state)
         OWNER_IDLE: begin
            if (m0_req || m1_req) begin
               grant_any = 1'b1;
               grant_id  = (m0_req && m1_req) ? ~last : m1_req;
               state_n   = (grant_id == M1) ? OWNER_M1 : OWNER_M0;
               cnt_n     = CNT_ONE;
               last_n    = grant_id;
            end
         end

         OWNER_M0, OWNER_M1: begin
            if (owner_req && !(other_req && beat_cnt == CNT_MAX)) begin
               // Owner keeps the memory; count saturates when uncontended.
               grant_any = 1'b1;
               grant_id  = owner_id;
               if (beat_cnt != CNT_MAX)
                  cnt_n = beat_cnt + CNT_ONE;
            end else if (other_req) begin
               grant_any = 1'b1;
               grant_id  = ~owner_id;
               state_n   = (owner_id == M1) ? OWNER_M0 : OWNER_M1;
               cnt_n     = CNT_ONE;
               last_n    = ~owner_id;
            end else begin
               state_n = OWNER_IDLE;
               cnt_n   = '0;
            end
         end

         default: begin
            state_n = OWNER_IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   // Grants are suppressed while reset is asserted so nothing reaches memory.
   assign gnt_ok = grant_any & resetn;
   assign m0_gnt = gnt_ok & (grant_id == M0);
   assign m1_gnt = gnt_ok & (grant_id == M1);

   always_comb begin
      mem_we       = 1'b0;
      mem_address  = '0;
      mem_data_out = '0;
      if (m1_gnt) begin
         mem_we       = m1_we;
         mem_address  = m1_addr;
         mem_data_out = m1_wdata;
      end else if (m0_gnt) begin
         mem_we       = m0_we;
         mem_address  = m0_addr;
         mem_data_out = m0_wdata;
      end
   end

   assign read_beat = (m0_gnt | m1_gnt) & ~mem_we;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state    <= OWNER_IDLE;
         last     <= M1;
         beat_cnt <= '0;
         rd_pend  <= 1'b0;
         rd_id    <= M0;
      end else begin
         state    <= state_n;
         last     <= last_n;
         beat_cnt <= cnt_n;
         rd_pend  <= read_beat;
         rd_id    <= m1_gnt;
      end
   end

   // Memory returns data one cycle after the address, so it lines up with rd_pend.
   assign m0_rvalid = resetn & rd_pend & (rd_id == M0);
   assign m1_rvalid = resetn & rd_pend & (rd_id == M1);
   assign rdata     = mem_data_in;
   assign dbg_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic against a behavioural grant/memory reference model.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int AW        = 32;
   localparam int DW        = 32;
   localparam int BURST_MAX = 4;

   logic          clk;
   logic          resetn;
   logic          m0_req, m0_we, m0_gnt, m0_rvalid;
   logic [AW-1:0] m0_addr;
   logic [DW-1:0] m0_wdata;
   logic          m1_req, m1_we, m1_gnt, m1_rvalid;
   logic [AW-1:0] m1_addr;
   logic [DW-1:0] m1_wdata;
   logic [DW-1:0] rdata;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_data_out;
   logic          mem_we;
   logic [DW-1:0] mem_data_in;
   owner_e        dbg_state;

   mem_arbiter #(.AW(AW), .DW(DW), .BURST_MAX(BURST_MAX)) dut (
      .clk(clk), .resetn(resetn),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
      .rdata(rdata), .mem_address(mem_address), .mem_data_out(mem_data_out),
      .mem_we(mem_we), .mem_data_in(mem_data_in), .dbg_state(dbg_state)
   );

   // ---------------- clock / memory ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [DW-1:0] mem_arr [0:4095];
   logic [DW-1:0] ref_mem [0:4095];

   always @(posedge clk) begin
      if (mem_we) mem_arr[mem_address[11:0]] <= mem_data_out;
      mem_data_in <= mem_arr[mem_address[11:0]];
   end

   // ---------------- reference model ----------------
   int checks = 0;
   int errors = 0;
   int prev_owner;   // master granted last cycle, -1 if none
   int run;          // consecutive grants to prev_owner
   int last_id;      // most recently granted master
   logic [DW:0] exp_q[$];  // {id, data} of read answered next cycle

   logic          exp_g0, exp_g1, exp_mwe, exp_rv0, exp_rv1;
   logic [AW-1:0] exp_maddr;
   logic [DW-1:0] exp_mdata, exp_rdata;

   task automatic drive_cycle(input logic rn,
                              input logic r0, input logic w0,
                              input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                              input logic r1, input logic w1,
                              input logic [AW-1:0] a1, input logic [DW-1:0] d1);
      int eg;
      logic [DW:0] ent;
      @(negedge clk);
      resetn = rn;
      m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
      m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
      #1;
      exp_rv0 = 1'b0; exp_rv1 = 1'b0; exp_rdata = '0;
      if (exp_q.size() > 0) begin
         ent = exp_q.pop_front();
         if (rn) begin
            if (ent[DW]) exp_rv1 = 1'b1; else exp_rv0 = 1'b1;
            exp_rdata = ent[DW-1:0];
         end
      end
      eg = -1;
      if (rn) begin
         if (r0 && !r1) eg = 0;
         else if (r1 && !r0) eg = 1;
         else if (r0 && r1) begin
            if (prev_owner < 0) eg = 1 - last_id;
            else if (run < BURST_MAX) eg = prev_owner;
            else eg = 1 - prev_owner;
         end
      end
      exp_g0 = (eg == 0);
      exp_g1 = (eg == 1);
      exp_mwe = 1'b0; exp_maddr = '0; exp_mdata = '0;
      if (eg == 0) begin exp_mwe = w0; exp_maddr = a0; exp_mdata = d0; end
      if (eg == 1) begin exp_mwe = w1; exp_maddr = a1; exp_mdata = d1; end
      if (!rn) begin
         prev_owner = -1; run = 0; last_id = 1;
         exp_q.delete();
      end else begin
         if (eg >= 0) begin
            run = (eg == prev_owner) ? run + 1 : 1;
            last_id = eg;
            if (exp_mwe) ref_mem[exp_maddr[11:0]] = exp_mdata;
            else exp_q.push_back({(eg == 1), ref_mem[exp_maddr[11:0]]});
         end
         prev_owner = eg;
      end
   endtask

   task automatic idle_cycle(input logic rn);
      drive_cycle(rn, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      for (int i = 0; i < 5; i++) begin
         drive_cycle(1'b0, 1'b1, 1'b0, 32'h40, '0, 1'b1, 1'b0, 32'h44, '0);
         checks++;
         if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
            errors++; $display("FAIL reset_gnt cyc %0d: got %b%b need 00", i, m0_gnt, m1_gnt);
         end
         checks++;
         if (mem_we !== 1'b0) begin
            errors++; $display("FAIL reset_mem_we cyc %0d: got %b need 0", i, mem_we);
         end
         checks++;
         if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
            errors++; $display("FAIL reset_rvalid cyc %0d: got %b%b need 00", i, m0_rvalid, m1_rvalid);
         end
      end
      checks++;
      if (dbg_state !== OWNER_IDLE) begin
         errors++; $display("FAIL reset_state: got %0d need %0d", dbg_state, OWNER_IDLE);
      end
      drive_cycle(1'b1, 1'b1, 1'b0, 32'h40, '0, 1'b1, 1'b0, 32'h44, '0);
      checks++;
      if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
         errors++; $display("FAIL reset_first_win: got %b%b need 10", m0_gnt, m1_gnt);
      end
      idle_cycle(1'b1);
      checks++;
      if (m0_rvalid !== 1'b1 || rdata !== exp_rdata) begin
         errors++; $display("FAIL reset_first_read: rv %b rdata %h need 1 %h", m0_rvalid, rdata, exp_rdata);
      end
   endtask

   task automatic test_single_master();
      drive_cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 32'h800, 32'hDEADBEEF);
      checks++;
      if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin
         errors++; $display("FAIL single_wr_gnt: got %b%b need 01", m0_gnt, m1_gnt);
      end
      checks++;
      if (mem_we !== 1'b1 || mem_address !== 32'h800 || mem_data_out !== 32'hDEADBEEF) begin
         errors++; $display("FAIL single_wr_bus: we %b addr %h data %h need 1 800 deadbeef",
                            mem_we, mem_address, mem_data_out);
      end
      drive_cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h800, '0);
      checks++;
      if (m1_gnt !== 1'b1 || m1_rvalid !== 1'b0 || m0_rvalid !== 1'b0) begin
         errors++; $display("FAIL single_rd_gnt: gnt %b rv %b%b need 1 00", m1_gnt, m0_rvalid, m1_rvalid);
      end
      idle_cycle(1'b1);
      checks++;
      if (m1_rvalid !== 1'b1 || m0_rvalid !== 1'b0 || rdata !== 32'hDEADBEEF) begin
         errors++; $display("FAIL single_rd_data: rv %b%b rdata %h need 01 deadbeef",
                            m0_rvalid, m1_rvalid, rdata);
      end
      idle_cycle(1'b1);
      checks++;
      if (m1_rvalid !== 1'b0) begin
         errors++; $display("FAIL single_rv_pulse: got %b need 0", m1_rvalid);
      end
   endtask

   task automatic test_burst();
      int id, pid;
      for (int i = 0; i < 12; i++) begin
         drive_cycle(1'b1, 1'b1, 1'b0, 32'h100 + 4*i, '0, 1'b1, 1'b0, 32'h200 + 4*i, '0);
         id = (i / 4) % 2;
         checks++;
         if (m0_gnt !== (id == 0) || m1_gnt !== (id == 1)) begin
            errors++; $display("FAIL burst_gnt cyc %0d: got %b%b need m%0d", i, m0_gnt, m1_gnt, id);
         end
         if (i > 0) begin
            pid = ((i - 1) / 4) % 2;
            checks++;
            if (m0_rvalid !== (pid == 0) || m1_rvalid !== (pid == 1) || rdata !== exp_rdata) begin
               errors++; $display("FAIL burst_rv cyc %0d: rv %b%b rdata %h need m%0d %h",
                                  i, m0_rvalid, m1_rvalid, rdata, pid, exp_rdata);
            end
         end
      end
      idle_cycle(1'b1);
      checks++;
      if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0 || rdata !== exp_rdata) begin
         errors++; $display("FAIL burst_tail_rv: rv %b%b rdata %h need 10 %h", m0_rvalid, m1_rvalid, rdata, exp_rdata);
      end
   endtask

   task automatic test_owner_drop();
      drive_cycle(1'b1, 1'b1, 1'b0, 32'h30, '0, 1'b0, 1'b0, '0, '0);
      drive_cycle(1'b1, 1'b1, 1'b0, 32'h34, '0, 1'b1, 1'b0, 32'h38, '0);
      checks++;
      if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
         errors++; $display("FAIL drop_own_beat2: got %b%b need 10", m0_gnt, m1_gnt);
      end
      drive_cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h38, '0);
      checks++;
      if (m0_gnt !== 1'b0 || m1_gnt !== 1'b1) begin
         errors++; $display("FAIL drop_handover: got %b%b need 01", m0_gnt, m1_gnt);
      end
      drive_cycle(1'b1, 1'b1, 1'b0, 32'h3c, '0, 1'b1, 1'b0, 32'h40, '0);
      checks++;
      if (m0_gnt !== 1'b0 || m1_gnt !== 1'b1) begin
         errors++; $display("FAIL drop_new_owner: got %b%b need 01", m0_gnt, m1_gnt);
      end
      idle_cycle(1'b1);
   endtask

   task automatic test_alternate();
      drive_cycle(1'b1, 1'b1, 1'b1, 32'h10, 32'h11110010, 1'b0, 1'b0, '0, '0);
      drive_cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 32'h14, 32'h22220014);
      idle_cycle(1'b1);
      drive_cycle(1'b1, 1'b1, 1'b0, 32'h10, '0, 1'b0, 1'b0, '0, '0);
      checks++;
      if (m0_gnt !== 1'b1) begin
         errors++; $display("FAIL alt_m0_gnt: got %b need 1", m0_gnt);
      end
      drive_cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h14, '0);
      checks++;
      if (m1_gnt !== 1'b1 || m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0 || rdata !== 32'h11110010) begin
         errors++; $display("FAIL alt_m0_rv: gnt1 %b rv %b%b rdata %h need 1 10 11110010",
                            m1_gnt, m0_rvalid, m1_rvalid, rdata);
      end
      drive_cycle(1'b1, 1'b1, 1'b1, 32'h20, 32'hCAFE0020, 1'b0, 1'b0, '0, '0);
      checks++;
      if (m0_gnt !== 1'b1 || m1_rvalid !== 1'b1 || m0_rvalid !== 1'b0 || rdata !== 32'h22220014) begin
         errors++; $display("FAIL alt_m1_rv: gnt0 %b rv %b%b rdata %h need 1 01 22220014",
                            m0_gnt, m0_rvalid, m1_rvalid, rdata);
      end
      drive_cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h20, '0);
      idle_cycle(1'b1);
      checks++;
      if (m1_rvalid !== 1'b1 || rdata !== 32'hCAFE0020) begin
         errors++; $display("FAIL alt_raw: rv %b rdata %h need 1 cafe0020", m1_rvalid, rdata);
      end
   endtask

   task automatic test_reset_mid();
      drive_cycle(1'b1, 1'b1, 1'b0, 32'h10, '0, 1'b0, 1'b0, '0, '0);
      checks++;
      if (m0_gnt !== 1'b1) begin
         errors++; $display("FAIL rmid_gnt: got %b need 1", m0_gnt);
      end
      drive_cycle(1'b0, 1'b1, 1'b0, 32'h10, '0, 1'b0, 1'b0, '0, '0);
      checks++;
      if (m0_rvalid !== 1'b0 || m0_gnt !== 1'b0) begin
         errors++; $display("FAIL rmid_rv_in_reset: rv %b gnt %b need 0 0", m0_rvalid, m0_gnt);
      end
      idle_cycle(1'b1);
      checks++;
      if (m0_rvalid !== 1'b0 || dbg_state !== OWNER_IDLE) begin
         errors++; $display("FAIL rmid_after: rv %b state %0d need 0 %0d", m0_rvalid, dbg_state, OWNER_IDLE);
      end
      drive_cycle(1'b1, 1'b1, 1'b0, 32'h50, '0, 1'b1, 1'b0, 32'h54, '0);
      checks++;
      if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
         errors++; $display("FAIL rmid_last_reset: got %b%b need 10", m0_gnt, m1_gnt);
      end
      idle_cycle(1'b1);
   endtask

   task automatic test_random();
      logic rn, r0, r1, w0, w1;
      logic [AW-1:0] a0, a1;
      logic [DW-1:0] d0, d1;
      for (int i = 0; i < 3000; i++) begin
         rn = ($urandom_range(0, 99) != 0);
         r0 = ($urandom_range(0, 3) != 0);
         r1 = ($urandom_range(0, 3) != 0);
         w0 = ($urandom_range(0, 2) == 0);
         w1 = ($urandom_range(0, 2) == 0);
         a0 = AW'($urandom_range(0, 15) * 4) | ($urandom_range(0, 1) ? 32'h1000_0000 : 32'h0);
         a1 = AW'($urandom_range(0, 15) * 4) | ($urandom_range(0, 1) ? 32'h0200_0000 : 32'h0);
         d0 = $urandom;
         d1 = $urandom;
         drive_cycle(rn, r0, w0, a0, d0, r1, w1, a1, d1);
         checks++;
         if (m0_gnt !== exp_g0 || m1_gnt !== exp_g1) begin
            errors++; $display("FAIL rand_gnt cyc %0d: got %b%b need %b%b", i, m0_gnt, m1_gnt, exp_g0, exp_g1);
         end
         checks++;
         if (mem_we !== exp_mwe || mem_address !== exp_maddr || mem_data_out !== exp_mdata) begin
            errors++; $display("FAIL rand_bus cyc %0d: we %b addr %h data %h need %b %h %h",
                               i, mem_we, mem_address, mem_data_out, exp_mwe, exp_maddr, exp_mdata);
         end
         checks++;
         if (m0_rvalid !== exp_rv0 || m1_rvalid !== exp_rv1) begin
            errors++; $display("FAIL rand_rv cyc %0d: got %b%b need %b%b", i, m0_rvalid, m1_rvalid, exp_rv0, exp_rv1);
         end
         if (exp_rv0 || exp_rv1) begin
            checks++;
            if (rdata !== exp_rdata) begin
               errors++; $display("FAIL rand_rdata cyc %0d: got %h need %h", i, rdata, exp_rdata);
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) begin
         mem_arr[i] = DW'(i) * 32'h0001_0003 ^ 32'hA5A5_0000;
         ref_mem[i] = DW'(i) * 32'h0001_0003 ^ 32'hA5A5_0000;
      end
      prev_owner = -1; run = 0; last_id = 1;
      resetn = 1'b0;
      m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
      m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;

      test_reset();
      test_single_master();
      test_burst();
      test_owner_drop();
      test_alternate();
      test_reset_mid();
      test_random();
      idle_cycle(1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
